// File: rtl/i2s_rx_pkg.sv
// Shared types and reset constants for the I2S receiver.
// I2S_RX_LEFT_JUSTIFIED_EN selects left-justified framing (LRCK high = left, no one-bit delay).
package i2s_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        CH_L = 1'b0,
        CH_R = 1'b1
    } ch_e;

    localparam logic SYNC_RST      = 1'b0;
    localparam logic LRCK_PREV_RST = 1'b1;

`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    localparam logic LRCK_LEFT_LVL   = 1'b1;
    localparam logic CAPTURE_ON_EDGE = 1'b1;
`else
    localparam logic LRCK_LEFT_LVL   = 1'b0;
    localparam logic CAPTURE_ON_EDGE = 1'b0;
`endif

endpackage

// File: rtl/i2s_rx_sync.sv
// Synchronizer chains for the asynchronous I2S pins plus a BCLK rising-edge strobe.
// All three chains have equal depth so lrck_s/sdata_s line up with the strobe.
module i2s_rx_sync
    import i2s_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic hclkin,
    input  logic reset,
    input  logic bclk_i,
    input  logic lrck_i,
    input  logic sdata_i,
    output logic brise,
    output logic lrck_s,
    output logic sdata_s
);

    logic [SYNC_STAGES-1:0] bclk_sync_d, bclk_sync_q;
    logic [SYNC_STAGES-1:0] lrck_sync_d, lrck_sync_q;
    logic [SYNC_STAGES-1:0] sdata_sync_d, sdata_sync_q;
    logic                   bclk_dly_d, bclk_dly_q;

    always_comb begin
        bclk_sync_d  = {bclk_sync_q[SYNC_STAGES-2:0], bclk_i};
        lrck_sync_d  = {lrck_sync_q[SYNC_STAGES-2:0], lrck_i};
        sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], sdata_i};
        bclk_dly_d   = bclk_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge hclkin) begin
        if (reset) begin
            bclk_sync_q  <= {SYNC_STAGES{SYNC_RST}};
            lrck_sync_q  <= {SYNC_STAGES{SYNC_RST}};
            sdata_sync_q <= {SYNC_STAGES{SYNC_RST}};
            bclk_dly_q   <= SYNC_RST;
        end else begin
            bclk_sync_q  <= bclk_sync_d;
            lrck_sync_q  <= lrck_sync_d;
            sdata_sync_q <= sdata_sync_d;
            bclk_dly_q   <= bclk_dly_d;
        end
    end

    assign brise   = bclk_sync_q[SYNC_STAGES-1] & ~bclk_dly_q;
    assign lrck_s  = lrck_sync_q[SYNC_STAGES-1];
    assign sdata_s = sdata_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/i2s_rx_deser.sv
// I2S receiver: oversampled bus, stereo pair on a valid/ready register, overrun and framing pulses.
// I2S_RX_LEFT_JUSTIFIED_EN switches to left-justified framing.
//   state | meaning
//   IDLE  | unaligned, waiting for an LRCK edge into the left channel
//   SHIFT | capturing DATA_W bits of the current channel, MSB first
//   WAIT  | word captured, counting slot padding until the next LRCK edge
module i2s_rx_deser
    import i2s_rx_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int SLOT_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              hclkin,
    input  logic              reset,
    input  logic              bclk_i,
    input  logic              lrck_i,
    input  logic              sdata_i,
    output logic [DATA_W-1:0] sample_l_o,
    output logic [DATA_W-1:0] sample_r_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              overrun_o,
    output logic              frame_err_o
);

    localparam int               CNT_W    = $clog2(SLOT_W + 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] SLOT_LIM = CNT_W'(SLOT_W);
    localparam logic [CNT_W-1:0] WORD_LEN = CNT_W'(DATA_W);

    logic brise, lrck_s, sdata_s;

    i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .hclkin  (hclkin),
        .reset   (reset),
        .bclk_i  (bclk_i),
        .lrck_i  (lrck_i),
        .sdata_i (sdata_i),
        .brise   (brise),
        .lrck_s  (lrck_s),
        .sdata_s (sdata_s)
    );

    state_e            state_d, state_q;
    ch_e               ch_d, ch_q, lrck_ch;
    logic [CNT_W-1:0]  bitcnt_d, bitcnt_q;
    logic [DATA_W-1:0] shreg_d, shreg_q, hold_l_d, hold_l_q;
    logic [DATA_W-1:0] sample_l_d, sample_l_q, sample_r_d, sample_r_q;
    logic              lrck_prev_d, lrck_prev_q;
    logic              valid_d, valid_q, overrun_d, overrun_q, frame_err_d, frame_err_q;
    logic              lrck_edge, start, capture, complete, handshake;
    logic [DATA_W:0]   shift_ext;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        hold_l_d    = hold_l_q;
        lrck_prev_d = lrck_prev_q;
        frame_err_d = 1'b0;
        start       = 1'b0;
        capture     = 1'b0;
        complete    = 1'b0;
        lrck_edge   = brise && (lrck_s != lrck_prev_q);
        lrck_ch     = (lrck_s == LRCK_LEFT_LVL) ? CH_L : CH_R;
        shift_ext   = {shreg_q, sdata_s};

        if (brise) begin
            lrck_prev_d = lrck_s;
            unique case (state_q)
                IDLE: begin
                    if (lrck_edge && lrck_ch == CH_L) start = 1'b1;
                end
                SHIFT: begin
                    if (lrck_edge) begin
                        start       = 1'b1;
                        frame_err_d = 1'b1;
                    end else begin
                        capture = 1'b1;
                    end
                end
                WAIT: begin
                    if (lrck_edge) begin
                        if (lrck_ch != ch_q) begin
                            start = 1'b1;
                        end else begin
                            state_d     = IDLE;
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        if (bitcnt_q != CNT_MAX) bitcnt_d = bitcnt_q + CNT_ONE;
                        if (bitcnt_d > SLOT_LIM) begin
                            state_d     = IDLE;
                            frame_err_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Left-justified framing also captures the MSB on the edge strobe itself
        if (start) begin
            state_d  = SHIFT;
            ch_d     = lrck_ch;
            bitcnt_d = '0;
            capture  = CAPTURE_ON_EDGE;
        end

        if (capture) begin
            shreg_d  = shift_ext[DATA_W-1:0];
            bitcnt_d = bitcnt_d + CNT_ONE;
            if (bitcnt_d == WORD_LEN) begin
                state_d = WAIT;
                if (ch_d == CH_L) hold_l_d = shreg_d;
                else              complete = 1'b1;
            end
        end
    end

    always_comb begin
        handshake  = valid_q & ready_i;
        valid_d    = valid_q & ~handshake;
        sample_l_d = sample_l_q;
        sample_r_d = sample_r_q;
        overrun_d  = 1'b0;
        if (complete) begin
            if (!valid_q || handshake) begin
                sample_l_d = hold_l_q;
                sample_r_d = shreg_d;
                valid_d    = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge hclkin) begin
        if (reset) begin
            state_q     <= IDLE;
            ch_q        <= CH_L;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            hold_l_q    <= '0;
            lrck_prev_q <= LRCK_PREV_RST;
            sample_l_q  <= '0;
            sample_r_q  <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            hold_l_q    <= hold_l_d;
            lrck_prev_q <= lrck_prev_d;
            sample_l_q  <= sample_l_d;
            sample_r_q  <= sample_r_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign sample_l_o  = sample_l_q;
    assign sample_r_o  = sample_r_q;
    assign valid_o     = valid_q;
    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Self-checking bench for i2s_rx_deser: frame table, corner sequences, random frames vs a frame-level model.
// Honours I2S_RX_LEFT_JUSTIFIED_EN when the whole build defines it.
`timescale 1ns/1ps
module tb_i2s_rx_deser;

    localparam int DATA_W    = 16;
    localparam int SLOT_W    = 32;
    localparam int HALF_BCLK = 4;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
    localparam bit   LJ       = 1'b1;
    localparam logic LEFT_LVL = 1'b1;
`else
    localparam bit   LJ       = 1'b0;
    localparam logic LEFT_LVL = 1'b0;
`endif
    localparam logic RIGHT_LVL = ~LEFT_LVL;

    logic              hclkin, reset, bclk_i, lrck_i, sdata_i, ready_i;
    logic [DATA_W-1:0] sample_l_o, sample_r_o;
    logic              valid_o, overrun_o, frame_err_o;

    i2s_rx_deser #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .SYNC_STAGES(2)) dut (
        .hclkin      (hclkin),
        .reset       (reset),
        .bclk_i      (bclk_i),
        .lrck_i      (lrck_i),
        .sdata_i     (sdata_i),
        .sample_l_o  (sample_l_o),
        .sample_r_o  (sample_r_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .overrun_o   (overrun_o),
        .frame_err_o (frame_err_o)
    );

    initial hclkin = 1'b0;
    always #5 hclkin = ~hclkin;

    typedef struct packed {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } pair_t;

    typedef struct {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
        int                sl;
        int                sr;
        logic [DATA_W-1:0] exp_l;
        logic [DATA_W-1:0] exp_r;
    } vec_t;

    int    n_vec = 0;
    int    n_err = 0;
    int    ovr_cnt = 0;
    int    ferr_cnt = 0;
    pair_t got_q[$];
    pair_t exp_q[$];
    pair_t mon_pair;
    logic  prev_hold = 1'b0;
    logic [DATA_W-1:0] prev_l, prev_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Captures handshakes, counts pulses, and checks samples stay put while held
    always @(negedge hclkin) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_l", 32'(sample_l_o), 32'(prev_l));
                check("hold_r", 32'(sample_r_o), 32'(prev_r));
            end
            if (valid_o && ready_i) begin
                mon_pair.l = sample_l_o;
                mon_pair.r = sample_r_o;
                got_q.push_back(mon_pair);
            end
            if (overrun_o)   ovr_cnt++;
            if (frame_err_o) ferr_cnt++;
            prev_hold = valid_o && !ready_i;
            prev_l    = sample_l_o;
            prev_r    = sample_r_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge hclkin);
        #1;
    endtask

    // Bit carried by BCLK period p of a half-frame
    function automatic logic ser_bit(input logic [DATA_W-1:0] w, input int p);
        int k;
        k = LJ ? p : p - 1;
        if (k >= 0 && k < DATA_W) return w[DATA_W-1-k];
        return logic'($urandom_range(1, 0));
    endfunction

    task automatic bclk_bit(input logic lr, input logic d);
        bclk_i  = 1'b0;
        lrck_i  = lr;
        sdata_i = d;
        tick(HALF_BCLK);
        bclk_i = 1'b1;
        tick(HALF_BCLK);
    endtask

    task automatic send_half(input logic lr, input logic [DATA_W-1:0] w, input int nbits);
        for (int p = 0; p < nbits; p++) bclk_bit(lr, ser_bit(w, p));
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                              input int sl, input int sr);
        send_half(LEFT_LVL, l, sl);
        send_half(RIGHT_LVL, r, sr);
    endtask

    task automatic settle();
        bclk_i = 1'b0;
        tick(12);
    endtask

    task automatic check_last(input string name, input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        pair_t last;
        last = (got_q.size() > 0) ? got_q[got_q.size()-1] : '0;
        check({name, "_l"}, 32'(last.l), 32'(l));
        check({name, "_r"}, 32'(last.r), 32'(r));
    endtask

    vec_t tbl[6];
    int   n0, f0, o0;
    pair_t rp;

    initial begin
        tbl[0] = '{16'hA5C3, 16'h1234, 32, 32, 16'hA5C3, 16'h1234};
        tbl[1] = '{16'hFFFF, 16'h0000, 17, 17, 16'hFFFF, 16'h0000};
        tbl[2] = '{16'h0000, 16'hFFFF, 32, 17, 16'h0000, 16'hFFFF};
        tbl[3] = '{16'h8001, 16'h7FFE, 24, 32, 16'h8001, 16'h7FFE};
        tbl[4] = '{16'h0F0F, 16'hF0F0, 17, 32, 16'h0F0F, 16'hF0F0};
        tbl[5] = '{16'h5555, 16'hAAAA, 20, 25, 16'h5555, 16'hAAAA};

        reset   = 1'b1;
        bclk_i  = 1'b0;
        lrck_i  = RIGHT_LVL;
        sdata_i = 1'b0;
        ready_i = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_l", 32'(sample_l_o), 32'd0);
        check("rst_r", 32'(sample_r_o), 32'd0);
        check("rst_ovr", 32'(overrun_o), 32'd0);
        check("rst_ferr", 32'(frame_err_o), 32'd0);

        send_half(RIGHT_LVL, '0, 3);

        for (int i = 0; i < 6; i++) begin
            n0 = got_q.size();
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            send_frame(tbl[i].l, tbl[i].r, tbl[i].sl, tbl[i].sr);
            settle();
            check("tbl_count", 32'(got_q.size() - n0), 32'd1);
            check_last("tbl", tbl[i].exp_l, tbl[i].exp_r);
            check("tbl_ferr", 32'(ferr_cnt - f0), 32'd0);
            check("tbl_ovr", 32'(ovr_cnt - o0), 32'd0);
        end

        // Back-pressure across two frames: the second pair is dropped
        ready_i = 1'b0;
        n0 = got_q.size();
        o0 = ovr_cnt;
        send_frame(16'h1111, 16'h2222, 32, 32);
        send_frame(16'h3333, 16'h4444, 32, 32);
        settle();
        check("ovr_valid", 32'(valid_o), 32'd1);
        check("ovr_l", 32'(sample_l_o), 32'h1111);
        check("ovr_r", 32'(sample_r_o), 32'h2222);
        check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_nohs", 32'(got_q.size() - n0), 32'd0);
        ready_i = 1'b1;
        tick(2);
        check("ovr_hs", 32'(got_q.size() - n0), 32'd1);
        check_last("ovr_hs", 16'h1111, 16'h2222);
        check("ovr_clr", 32'(valid_o), 32'd0);

        // LRCK toggles after 10 left bits
        f0 = ferr_cnt;
        send_half(LEFT_LVL, 16'hABCD, 11);
        send_half(RIGHT_LVL, 16'h9999, 32);
        settle();
        check("short_ferr", 32'(ferr_cnt - f0), 32'd1);
        n0 = got_q.size();
        send_frame(16'h0F0F, 16'hF0F0, 32, 32);
        settle();
        check("short_next", 32'(got_q.size() - n0), 32'd1);
        check_last("short_next", 16'h0F0F, 16'hF0F0);
        check("short_ferr2", 32'(ferr_cnt - f0), 32'd1);

        // LRCK stuck for 40 BCLKs
        f0 = ferr_cnt;
        n0 = got_q.size();
        send_half(LEFT_LVL, 16'h1357, 40);
        settle();
        check("long_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("long_valid", 32'(valid_o), 32'd0);
        send_half(RIGHT_LVL, 16'h0000, 20);
        settle();
        check("long_idle", 32'(got_q.size() - n0), 32'd0);
        check("long_idle_v", 32'(valid_o), 32'd0);
        send_frame(16'h2468, 16'h9BDF, 32, 32);
        settle();
        check("long_next", 32'(got_q.size() - n0), 32'd1);
        check_last("long_next", 16'h2468, 16'h9BDF);
        check("long_ferr2", 32'(ferr_cnt - f0), 32'd1);

        // Reset in the middle of the right word
        n0 = got_q.size();
        send_half(LEFT_LVL, 16'hDEAD, 32);
        send_half(RIGHT_LVL, 16'hBEEF, 8);
        bclk_i = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);
        check("mrst_valid", 32'(valid_o), 32'd0);
        check("mrst_l", 32'(sample_l_o), 32'd0);
        check("mrst_r", 32'(sample_r_o), 32'd0);
        send_half(RIGHT_LVL, 16'hBEEF, 24);
        settle();
        check("mrst_none", 32'(got_q.size() - n0), 32'd0);
        check("mrst_none_v", 32'(valid_o), 32'd0);
        send_frame(16'hCAFE, 16'h0123, 32, 32);
        settle();
        check("mrst_next", 32'(got_q.size() - n0), 32'd1);
        check_last("mrst_next", 16'hCAFE, 16'h0123);

        // Random frames against a frame-level queue model
        n0 = got_q.size();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        exp_q.delete();
        for (int i = 0; i < 24; i++) begin
            rp.l = DATA_W'($urandom);
            rp.r = DATA_W'($urandom);
            exp_q.push_back(rp);
            send_frame(rp.l, rp.r, $urandom_range(SLOT_W, DATA_W + 1),
                       $urandom_range(SLOT_W, DATA_W + 1));
        end
        settle();
        check("rnd_count", 32'(got_q.size() - n0), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            rp = (n0 + i < got_q.size()) ? got_q[n0 + i] : '0;
            check("rnd_l", 32'(rp.l), 32'(exp_q[i].l));
            check("rnd_r", 32'(rp.r), 32'(exp_q[i].r));
        end
        check("rnd_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("rnd_ovr", 32'(ovr_cnt - o0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2s_rx_deser.md
# i2s_rx_deser

Single-clock I2S receiver: oversamples an external BCLK/LRCK/SDATA bus in the `hclkin` domain and deserializes stereo sample pairs. It is the consuming end of the divided bit/word clocks our audio path produces. It presents each left/right pair on a valid/ready output register for the downstream audio FIFO or DSP. Alignment loss and back-pressure drops are flagged.

## Interface
- `DATA_W`, 16: captured bits per channel, MSB first; 1..`SLOT_W`.
- `SLOT_W`, 32: maximum BCLK periods per LRCK half-frame.
- `SYNC_STAGES`, 2: synchronizer flops per input; ≥2.
- `hclkin`  in  1  system clock; must be ≥4× BCLK frequency.
- `reset`  in  1  synchronous, active-high reset.
- `bclk_i`  in  1  external bit clock, asynchronous.
- `lrck_i`  in  1  external word clock, asynchronous; low = left channel.
- `sdata_i`  in  1  serial data, asynchronous.
- `sample_l_o`  out  `DATA_W`  left sample of the held pair.
- `sample_r_o`  out  `DATA_W`  right sample of the held pair.
- `valid_o`  out  1  output pair valid.
- `ready_i`  in  1  downstream accepts the pair when `valid_o` and `ready_i` are both high.
- `overrun_o`  out  1  one-cycle pulse: a completed pair was dropped.
- `frame_err_o`  out  1  one-cycle pulse: half-frame too short or too long.

## Operation
- Each input passes through `SYNC_STAGES` flops. BCLK rising edge is detected as `bclk_s & ~bclk_d`, giving a one-cycle strobe `brise`. All further logic advances only on `brise`.
- On each `brise`: sample the synchronized SDATA, compare the synchronized LRCK with `lrck_prev`, then update `lrck_prev`.
- FSM states:
  - `IDLE`: on an LRCK 1→0 edge go to `SHIFT`, with ch=L and bitcnt=0. Other edges are ignored.
  - `SHIFT`: shift SDATA into the channel shift register and increment bitcnt. After `DATA_W` bits, latch the left holding register (ch=L) or complete the pair (ch=R), then go to `WAIT`.
  - `WAIT`: ignore data and keep incrementing bitcnt. An LRCK edge of the expected polarity goes to `SHIFT`, toggles ch, and clears bitcnt.
- Standard I2S delay: the `brise` that sees the LRCK change carries the previous word's LSB and is not captured. The MSB is taken on the following `brise`.
- Frame error, reported as a `frame_err_o` pulse with the partial word discarded:
  - An LRCK edge while in `SHIFT`: restart `SHIFT`, with the channel taken from the new LRCK level.
  - bitcnt exceeds `SLOT_W` in `WAIT`: go to `IDLE`.
  - An LRCK edge of the wrong polarity, which cannot occur at a legal edge: go to `IDLE`.
- Pair completion:
  - If `valid_o`=0, or handshake fires this cycle: load both output registers and set `valid_o`=1.
  - Otherwise: pulse `overrun_o`, keep the held pair, and drop the new one.
- A handshake with no completion in the same cycle clears `valid_o`.
- Reset values: `valid_o`=0, `overrun_o`=0, `frame_err_o`=0, samples=0, FSM=`IDLE`, `lrck_prev`=1, synchronizers=0.
- Reset mid-word discards everything. The first pair after reset needs a fresh LRCK 1→0 edge.
- bitcnt width is clog2(`SLOT_W`+2) and saturates; no wrap-around.

## Timing
- The `brise` strobe occurs `SYNC_STAGES`+1 `hclkin` cycles after the external BCLK rising edge.
- Shift and FSM registers update in the `brise` cycle.
- `valid_o` rises 1 cycle after the `brise` carrying right-channel bit `DATA_W`-1.
- `overrun_o` and `frame_err_o` are registered and aligned with that same completion or error cycle.
- Output samples are stable whenever `valid_o`=1 and change only in a handshake cycle or while `valid_o`=0.
- `ready_i` has no combinational path to any output.

## Configuration
- `I2S_RX_LEFT_JUSTIFIED_EN` defined:
  - Left-justified format with no one-bit delay: the MSB is captured on the `brise` that sees the LRCK edge.
  - LRCK high = left, so the `IDLE` exit edge and left/right polarities are inverted.
- Undefined: standard I2S as described above.

## Structure
- Package `i2s_rx_pkg`: FSM state enum (`IDLE`, `SHIFT`, `WAIT`), channel enum (`CH_L`, `CH_R`), reset constants.
- Sub-module `i2s_rx_sync`: parameterized synchronizer chain plus BCLK rise detector. It outputs `brise`, `lrck_s`, and `sdata_s`.

## Test plan
Common setup: `DATA_W`=16, `SLOT_W`=32, BCLK = `hclkin`/8.
- Send L=0xA5C3, R=0x1234, `ready_i`=1 → one `valid_o` pulse with exactly those values, and no error pulses.
- Hold `ready_i`=0 across two frames (0x1111/0x2222, then 0x3333/0x4444) → outputs remain 0x1111/0x2222, and `overrun_o` pulses once at the second completion.
- Toggle LRCK after 10 bits of the left word → `frame_err_o` pulse, then the next full frame 0x0F0F/0xF0F0 is received correctly.
- Hold LRCK constant for 40 BCLKs → `frame_err_o` pulse and FSM returns to `IDLE`; no valid until the next 1→0 edge.
- Assert `reset` mid right word, then release → `valid_o`=0 and no output from the partial frame; the next frame is received intact.
- With `I2S_RX_LEFT_JUSTIFIED_EN` defined: a left-justified stream with L=0x8001, R=0x7FFE → exact values captured.
